// File: rtl/pixel_group_scheduler.sv
// rtl/pixel_group_scheduler.sv - round-robin group lock and pixel arbiter emitting address events (optional timestamp: EBC_SCHED_TIMESTAMP_EN)
module pixel_group_scheduler #(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int GRP_ROWS  = 4,
    parameter int GRP_COLS  = 4,
    parameter int MAX_BURST = 0,
    parameter int TS_W      = 16,
    localparam int NGR      = ROWS / GRP_ROWS,
    localparam int NGC      = COLS / GRP_COLS,
    localparam int NUM_GRP  = NGR * NGC,
    localparam int X_W      = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int Y_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int G_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [ROWS-1:0][COLS-1:0]  req_i,
    input  logic                       evt_ready_i,
    output logic                       evt_valid_o,
    output logic [X_W-1:0]             x_add_o,
    output logic [Y_W-1:0]             y_add_o,
    output logic [G_W-1:0]             grp_idx_o,
    output logic [ROWS-1:0][COLS-1:0]  gnt_o,
    output logic                       grp_release_o,
    output logic                       active_o
`ifdef EBC_SCHED_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]            ts_o
`endif
);

    localparam int GPIX = GRP_ROWS * GRP_COLS;
    localparam int P_W  = (GPIX > 1) ? $clog2(GPIX) : 1;
    localparam int B_W  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    // Geometry must tile the array exactly; a bad split is refused at elaboration.
    if (ROWS % GRP_ROWS != 0) begin : g_bad_rows
        $error("ROWS must be a multiple of GRP_ROWS");
    end
    if (COLS % GRP_COLS != 0) begin : g_bad_cols
        $error("COLS must be a multiple of GRP_COLS");
    end
    if (TS_W < 1) begin : g_bad_ts
        $error("TS_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB_PIX,
        S_WAIT_ACK,
        S_RELEASE
    } state_e;

    state_e                     state_q, state_d;
    logic [G_W-1:0]             grp_ptr_q, grp_ptr_d;
    logic [G_W-1:0]             grp_q, grp_d;
    logic [P_W-1:0]             pix_ptr_q, pix_ptr_d;
    logic [P_W-1:0]             pix_cur_q, pix_cur_d;
    logic [B_W-1:0]             burst_q, burst_d;
    logic                       valid_q, valid_d;
    logic [X_W-1:0]             x_q, x_d;
    logic [Y_W-1:0]             y_q, y_d;
    logic [ROWS-1:0][COLS-1:0]  gnt_q, gnt_d;
    logic                       rel_q, rel_d;

    logic [NUM_GRP-1:0]         grp_req;
    logic                       grp_found;
    logic [G_W-1:0]             grp_next;
    int                         row_base;
    int                         col_base;
    logic [GPIX-1:0]            loc_req;
    logic                       pix_found;
    logic [P_W-1:0]             pix_next;
    logic [X_W-1:0]             pix_x;
    logic [Y_W-1:0]             pix_y;
    logic                       burst_ok;

`ifdef EBC_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0]            ts_cnt_q;
    logic [TS_W-1:0]            ts_q, ts_d;
`endif

    // OR-reduce each rectangular tile into one group request bit.
    always_comb begin
        grp_req = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            for (int r = 0; r < GRP_ROWS; r++) begin
                for (int c = 0; c < GRP_COLS; c++) begin
                    if (req_i[(g / NGC) * GRP_ROWS + r][(g % NGC) * GRP_COLS + c]) begin
                        grp_req[g] = 1'b1;
                    end
                end
            end
        end
    end

    // Round-robin group search starting just after the last released group.
    always_comb begin
        int idx;
        grp_found = 1'b0;
        grp_next  = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_GRP; i++) begin
            idx = (int'(grp_ptr_q) + i) % NUM_GRP;
            if (!grp_found && grp_req[G_W'(idx)]) begin
                grp_found = 1'b1;
                grp_next  = G_W'(idx);
            end
        end
    end

    // Origin of the locked tile in absolute array coordinates.
    always_comb begin
        row_base = (int'(grp_q) / NGC) * GRP_ROWS;
        col_base = (int'(grp_q) % NGC) * GRP_COLS;
    end

    // Requests of the locked tile, minus the pixel whose grant is on the wire right now
    // (it still shows its request this cycle because it only reacts to the grant).
    always_comb begin
        int r;
        int c;
        loc_req = '0;
        r       = 0;
        c       = 0;
        for (int l = 0; l < GPIX; l++) begin
            r = row_base + l / GRP_COLS;
            c = col_base + l % GRP_COLS;
            loc_req[l] = req_i[Y_W'(r)][X_W'(c)] & ~gnt_q[Y_W'(r)][X_W'(c)];
        end
    end

    // Round-robin pixel search inside the tile, starting after the last served pixel.
    always_comb begin
        int idx;
        pix_found = 1'b0;
        pix_next  = '0;
        idx       = 0;
        for (int i = 1; i <= GPIX; i++) begin
            idx = (int'(pix_ptr_q) + i) % GPIX;
            if (!pix_found && loc_req[P_W'(idx)]) begin
                pix_found = 1'b1;
                pix_next  = P_W'(idx);
            end
        end
        pix_y    = Y_W'(row_base + int'(pix_next) / GRP_COLS);
        pix_x    = X_W'(col_base + int'(pix_next) % GRP_COLS);
        burst_ok = (MAX_BURST == 0) || (int'(burst_q) < MAX_BURST);
    end

    // Scheduler next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grp_ptr_d = grp_ptr_q;
        grp_d     = grp_q;
        pix_ptr_d = pix_ptr_q;
        pix_cur_d = pix_cur_q;
        burst_d   = burst_q;
        valid_d   = valid_q;
        x_d       = x_q;
        y_d       = y_q;
        gnt_d     = '0;
        rel_d     = 1'b0;
`ifdef EBC_SCHED_TIMESTAMP_EN
        ts_d      = ts_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grp_found) begin
                    grp_d   = grp_next;
                    burst_d = '0;
                    state_d = S_ARB_PIX;
                end
            end
            S_ARB_PIX: begin
                if (pix_found && burst_ok) begin
                    x_d       = pix_x;
                    y_d       = pix_y;
                    pix_cur_d = pix_next;
                    valid_d   = 1'b1;
`ifdef EBC_SCHED_TIMESTAMP_EN
                    ts_d      = ts_cnt_q;
`endif
                    state_d   = S_WAIT_ACK;
                end else begin
                    rel_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_WAIT_ACK: begin
                // Event is committed; only the downstream handshake moves us on.
                if (evt_ready_i) begin
                    valid_d          = 1'b0;
                    gnt_d[y_q][x_q]  = 1'b1;
                    pix_ptr_d        = pix_cur_q;
                    burst_d          = burst_q + 1'b1;
                    state_d          = S_ARB_PIX;
                end
            end
            S_RELEASE: begin
                grp_ptr_d = grp_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset cancels any pending event or grant.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            grp_ptr_q <= G_W'(NUM_GRP - 1);
            grp_q     <= '0;
            pix_ptr_q <= P_W'(GPIX - 1);
            pix_cur_q <= '0;
            burst_q   <= '0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            gnt_q     <= '0;
            rel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grp_ptr_q <= grp_ptr_d;
            grp_q     <= grp_d;
            pix_ptr_q <= pix_ptr_d;
            pix_cur_q <= pix_cur_d;
            burst_q   <= burst_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            gnt_q     <= gnt_d;
            rel_q     <= rel_d;
        end
    end

`ifdef EBC_SCHED_TIMESTAMP_EN
    // Free-running timestamp counter and the per-event latched copy.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            ts_q     <= ts_d;
        end
    end

    assign ts_o = ts_q;
`endif

    assign evt_valid_o   = valid_q;
    assign x_add_o       = x_q;
    assign y_add_o       = y_q;
    assign grp_idx_o     = grp_q;
    assign gnt_o         = gnt_q;
    assign grp_release_o = rel_q;
    assign active_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pixel_group_scheduler.sv
// tb/tb_pixel_group_scheduler.sv - randomized self-checking bench for pixel_group_scheduler
module tb_pixel_group_scheduler;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int GR   = 4;
    localparam int GC   = 4;
    localparam int NGC  = COLS / GC;
    localparam int NG   = (ROWS / GR) * NGC;
    localparam int GP   = GR * GC;
    localparam int MAXB = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [ROWS-1:0][COLS-1:0] req = '0;
    logic                      evt_ready = 1'b0;
    logic                      evt_valid;
    logic [3:0]                x_add;
    logic [3:0]                y_add;
    logic [3:0]                grp_idx;
    logic [ROWS-1:0][COLS-1:0] gnt;
    logic                      grp_release;
    logic                      active;
`ifdef EBC_SCHED_TIMESTAMP_EN
    logic [15:0]               ts;
`endif

    typedef struct {
        int x;
        int y;
        int g;
        int t;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  gnt_bad = 0;
    int  stab_bad = 0;
    int  gnt_cnt = 0;
    int  rel_cnt = 0;
    int  exp_rel = 0;
    int  m_gp = NG - 1;
    int  m_pp = GP - 1;

    pixel_group_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .GRP_ROWS(GR), .GRP_COLS(GC),
        .MAX_BURST(MAXB), .TS_W(16)
    ) dut (
        .clk_i(clk),
        .reset_i(rst_n),
        .req_i(req),
        .evt_ready_i(evt_ready),
        .evt_valid_o(evt_valid),
        .x_add_o(x_add),
        .y_add_o(y_add),
        .grp_idx_o(grp_idx),
        .gnt_o(gnt),
        .grp_release_o(grp_release),
        .active_o(active)
`ifdef EBC_SCHED_TIMESTAMP_EN
        ,
        .ts_o(ts)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit grp_pending(input logic [ROWS-1:0][COLS-1:0] p, input int g);
        for (int l = 0; l < GP; l++) begin
            if (p[(g / NGC) * GR + l / GC][(g % NGC) * GC + l % GC]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference: serve a fixed pending set by group round-robin, pixel round-robin, burst cap.
    task automatic model_run(input logic [ROWS-1:0][COLS-1:0] pend_in);
        logic [ROWS-1:0][COLS-1:0] pend;
        int g, l, r, c, n;
        pend = pend_in;
        g = 0; l = 0; r = 0; c = 0;
        while (pend != '0) begin
            for (int i = 1; i <= NG; i++) begin
                g = (m_gp + i) % NG;
                if (grp_pending(pend, g)) break;
            end
            n = 0;
            exp_rel++;
            while ((MAXB == 0 || n < MAXB) && grp_pending(pend, g)) begin
                for (int i = 1; i <= GP; i++) begin
                    l = (m_pp + i) % GP;
                    r = (g / NGC) * GR + l / GC;
                    c = (g % NGC) * GC + l % GC;
                    if (pend[r][c]) break;
                end
                exp_q.push_back('{c, r, g, 0});
                pend[r][c] = 1'b0;
                m_pp = l;
                n++;
            end
            m_gp = g;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        gnt_bad = 0; stab_bad = 0; gnt_cnt = 0; rel_cnt = 0; exp_rel = 0;
    endtask

    // One clock: log transfers, grants, releases; pixels drop their request when granted.
    task automatic tick();
        logic [ROWS-1:0][COLS-1:0] expg;
        bit  px, pv;
        ev_t e;
        px = evt_valid && evt_ready;
        pv = evt_valid;
        e  = '{int'(x_add), int'(y_add), int'(grp_idx), 0};
        @(posedge clk);
        #1;
        cyc++;
        e.t  = cyc;
        expg = '0;
        if (px) begin
            obs_q.push_back(e);
            expg[e.y][e.x] = 1'b1;
        end
        if (gnt !== expg) gnt_bad++;
        if (pv && !px && (!evt_valid || int'(x_add) != e.x || int'(y_add) != e.y || int'(grp_idx) != e.g))
            stab_bad++;
        if (gnt != '0) gnt_cnt++;
        if (grp_release) rel_cnt++;
        req = req & ~gnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = -1;
        m_gp = NG - 1;
        m_pp = GP - 1;
        clear_obs();
    endtask

    task automatic drain(input int rdy_pct);
        int budget;
        int idle;
        budget = 3000;
        idle = 0;
        while (budget > 0 && !(obs_q.size() >= exp_q.size() && idle >= 4)) begin
            evt_ready = ($urandom_range(99) < rdy_pct);
            tick();
            idle = active ? 0 : idle + 1;
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '1; evt_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({evt_valid, grp_release, active} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b required 000", {evt_valid, grp_release, active});
        end
        checks++;
        if ({x_add, y_add, grp_idx} !== 12'h000) begin
            errors++; $display("FAIL reset_addr: got %h required 000", {x_add, y_add, grp_idx});
        end
        checks++;
        if (gnt !== '0) begin
            errors++; $display("FAIL reset_gnt: got %h required 0", gnt);
        end
        do_reset();
        tick();
        checks++;
        if (active !== 1'b0) begin
            errors++; $display("FAIL reset_idle: active %b required 0", active);
        end
    endtask

    task automatic test_single();
        int nbad;
        do_reset();
        evt_ready = 1'b1;
        req[3][5] = 1'b1;
        model_run(req);
        tick();
        checks++;
        if (evt_valid !== 1'b0 || active !== 1'b1) begin
            errors++; $display("FAIL single_latency1: valid %b active %b required 0 1", evt_valid, active);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || x_add !== 4'd5 || y_add !== 4'd3 || grp_idx !== 4'd1) begin
            errors++;
            $display("FAIL single_event: valid %b x %0d y %0d g %0d required 1 5 3 1", evt_valid, x_add, y_add, grp_idx);
        end
        tick();
        checks++;
        if (gnt[3][5] !== 1'b1 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL single_gnt: gnt %b valid %b required 1 0", gnt[3][5], evt_valid);
        end
        tick();
        checks++;
        if (grp_release !== 1'b1) begin
            errors++; $display("FAIL single_release: got %b required 1", grp_release);
        end
        tick();
        checks++;
        if (active !== 1'b0) begin
            errors++; $display("FAIL single_idle: active %b required 0", active);
        end
        drain(100);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].g != exp_q[i].g) nbad++;
        checks++;
        if (nbad != 0 || obs_q.size() != exp_q.size() || gnt_cnt != 1 || gnt_bad != 0 || rel_cnt != exp_rel) begin
            errors++;
            $display("FAIL single_seq: bad %0d events %0d/%0d gnts %0d gnt_bad %0d rel %0d/%0d",
                     nbad, obs_q.size(), exp_q.size(), gnt_cnt, gnt_bad, rel_cnt, exp_rel);
        end
    endtask

    task automatic test_persistent();
        int t0, t1, nalt;
        do_reset();
        evt_ready = 1'b1;
        req[0][0] = 1'b1;
        req[0][4] = 1'b1;
        t0 = 0; t1 = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!req[0][0]) begin t0++; if (t0 == 3) begin req[0][0] = 1'b1; t0 = 0; end end
            if (!req[0][4]) begin t1++; if (t1 == 3) begin req[0][4] = 1'b1; t1 = 0; end end
        end
        drain(100);
        nalt = 0;
        for (int i = 1; i < obs_q.size(); i++) if (obs_q[i].g == obs_q[i-1].g) nalt++;
        checks++;
        if (obs_q.size() < 8 || obs_q[0].g != 0) begin
            errors++; $display("FAIL persist_start: events %0d first grp %0d required >=8 and 0",
                               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].g : -1);
        end
        checks++;
        if (nalt != 0 || rel_cnt != obs_q.size()) begin
            errors++; $display("FAIL persist_alternate: repeats %0d releases %0d events %0d", nalt, rel_cnt, obs_q.size());
        end
        checks++;
        if (gnt_bad != 0 || stab_bad != 0) begin
            errors++; $display("FAIL persist_gnt: gnt_bad %0d stab_bad %0d required 0", gnt_bad, stab_bad);
        end
    endtask

    task automatic test_burst();
        int nbad;
        do_reset();
        req[0][0] = 1'b1; req[0][1] = 1'b1; req[1][0] = 1'b1; req[1][1] = 1'b1;
        req[4][0] = 1'b1;
        model_run(req);
        drain(100);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].g != exp_q[i].g) nbad++;
        checks++;
        if (nbad != 0 || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL burst_seq: %0d differ, got %0d events required %0d", nbad, obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_q.size() < 5 || obs_q[2].x != 0 || obs_q[2].y != 4 || obs_q[2].g != 4 || obs_q[4].y != 1 || obs_q[4].x != 1) begin
            errors++; $display("FAIL burst_order: third/fifth event not (4,0)/(1,1), events %0d", obs_q.size());
        end
        checks++;
        if (rel_cnt != 3 || gnt_bad != 0) begin
            errors++; $display("FAIL burst_release: releases %0d required 3, gnt_bad %0d", rel_cnt, gnt_bad);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req[8][8] = 1'b1; req[8][9] = 1'b1;
        model_run(req);
        drain(100);
        checks++;
        if (obs_q.size() != 2 || obs_q[1].t - obs_q[0].t != 2) begin
            errors++; $display("FAIL b2b_rate: events %0d spacing %0d required 2 and 2",
                               obs_q.size(), (obs_q.size() == 2) ? obs_q[1].t - obs_q[0].t : -1);
        end
    endtask

    task automatic test_backpressure();
        int sx, sy, nbad;
        do_reset();
        req[2][2] = 1'b1;
        model_run(req);
        tick(); tick();
        sx = int'(x_add); sy = int'(y_add);
        checks++;
        if (evt_valid !== 1'b1 || sx != 2 || sy != 2) begin
            errors++; $display("FAIL bp_event: valid %b x %0d y %0d required 1 2 2", evt_valid, sx, sy);
        end
        nbad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 3) req[2][2] = 1'b0;
            if (evt_valid !== 1'b1 || int'(x_add) != sx || int'(y_add) != sy) nbad++;
        end
        checks++;
        if (nbad != 0 || stab_bad != 0) begin
            errors++; $display("FAIL bp_stable: unstable cycles %0d stab_bad %0d required 0", nbad, stab_bad);
        end
        drain(100);
        checks++;
        if (obs_q.size() != 1 || gnt_cnt != 1 || gnt_bad != 0) begin
            errors++; $display("FAIL bp_deliver: events %0d gnts %0d gnt_bad %0d required 1 1 0", obs_q.size(), gnt_cnt, gnt_bad);
        end
    endtask

    task automatic test_reset_mid();
        int nbad;
        do_reset();
        req[5][9] = 1'b1; req[10][10] = 1'b1;
        tick(); tick();
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_wait: valid %b required 1", evt_valid);
        end
        evt_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({evt_valid, grp_release, active, x_add, y_add, grp_idx} !== 15'h0 || gnt !== '0) begin
            errors++; $display("FAIL rmid_async: outputs %h gnt %h required 0",
                               {evt_valid, grp_release, active, x_add, y_add, grp_idx}, gnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = -1; m_gp = NG - 1; m_pp = GP - 1;
        clear_obs();
        tick();
        checks++;
        if (gnt !== '0 || gnt_bad != 0) begin
            errors++; $display("FAIL rmid_nogrant: gnt %h required 0", gnt);
        end
        model_run(req);
        drain(100);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= obs_q.size() || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].g != exp_q[i].g) nbad++;
        checks++;
        if (nbad != 0 || obs_q.size() != 2 || obs_q[0].g != 6) begin
            errors++; $display("FAIL rmid_restart: %0d differ, events %0d, first grp %0d required 6",
                               nbad, obs_q.size(), (obs_q.size() > 0) ? obs_q[0].g : -1);
        end
    endtask

    task automatic test_random();
        int nbad, pct;
        do_reset();
        for (int round = 0; round < 8; round++) begin
            clear_obs();
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    req[r][c] = ($urandom_range(round % 2 == 0 ? 15 : 5) == 0);
            req[$urandom_range(ROWS - 1)][$urandom_range(COLS - 1)] = 1'b1;
            pct = $urandom_range(40, 100);
            model_run(req);
            drain(pct);
            nbad = 0;
            for (int i = 0; i < exp_q.size(); i++)
                if (i >= obs_q.size() || obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].g != exp_q[i].g) nbad++;
            checks++;
            if (nbad != 0 || obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL random_seq r%0d: %0d differ, got %0d events required %0d",
                                   round, nbad, obs_q.size(), exp_q.size());
            end
            checks++;
            if (rel_cnt != exp_rel || gnt_cnt != exp_q.size()) begin
                errors++; $display("FAIL random_counts r%0d: releases %0d/%0d gnts %0d/%0d",
                                   round, rel_cnt, exp_rel, gnt_cnt, exp_q.size());
            end
            checks++;
            if (gnt_bad != 0 || stab_bad != 0) begin
                errors++; $display("FAIL random_proto r%0d: gnt_bad %0d stab_bad %0d required 0", round, gnt_bad, stab_bad);
            end
        end
    endtask

`ifdef EBC_SCHED_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        evt_ready = 1'b1;
        while (cyc < 10) tick();
        req[1][1] = 1'b1;
        tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || ts !== 16'd12) begin
            errors++; $display("FAIL ts_first: valid %b ts %0d required 1 12", evt_valid, ts);
        end
        while (cyc < 40) tick();
        req[2][2] = 1'b1;
        tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || ts !== 16'd42) begin
            errors++; $display("FAIL ts_second: valid %b ts %0d required 1 42", evt_valid, ts);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_persistent();
        test_burst();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef EBC_SCHED_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
